// File: rtl/beep_pkg.sv
// Shared definitions for the beep scheduler slice.
//   state_t       : sequencer states (IDLE, ON, OFF, DONE)
//   REQ_BTN/HOST  : requester ids reported on grant_id
//   DEF_*         : default timing for a 2 MHz clock
//   cnt_width     : counter width able to hold 0..n-1 (minimum 1 bit)
//   at_least_one  : coerces a zero phase length to one tick
package beep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic REQ_BTN  = 1'b0;
  localparam logic REQ_HOST = 1'b1;

  localparam int DEF_TICK_DIV        = 20000;
  localparam int DEF_DEBOUNCE_CYCLES = 20000;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [7:0] at_least_one(input logic [7:0] v);
    return (v == 8'd0) ? 8'd1 : v;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: 2-flop synchronizer, stability counter, and a
// one-cycle pulse on every debounced rising edge.
// Ports:
//   clock, reset : 2 MHz clock, synchronous active-high reset
//   btn_raw      : asynchronous physical button
//   rise         : one-cycle pulse when the debounced level goes 0 -> 1
module btn_debounce
  import beep_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic rise
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // cnt counts consecutive synchronized samples that differ from the
  // debounced level; the level flips on the DEBOUNCE_CYCLES-th such sample.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
        rise  <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/beep_scheduler.sv
// Owns the beepboop btn line: arbitrates between the debounced button and
// the host command port, plays each granted request as count on/off pulses
// timed in ticks of TICK_DIV cycles, and pulses done at the end.
// Ports:
//   clock, reset        : 2 MHz clock, synchronous active-high reset
//   btn_raw             : asynchronous physical button
//   host_valid/ready    : host request handshake
//   host_count/on/off   : pulse count, on ticks, off ticks
//   btn_out             : drives beepboop btn
//   busy                : high in any state except IDLE
//   grant_id            : owner of current or last sequence (0 btn, 1 host)
//   done                : one-cycle pulse in the DONE state
//   state_dbg           : current FSM state (state_t encoding)
//
// Host handshake: a request transfers on a cycle where host_valid and
// host_ready are both high. host_ready is combinational and never depends
// on a handshake completing; the host holds host_valid and all fields stable
// until it sees host_ready, and may drop or change them the cycle after.
module beep_scheduler
  import beep_pkg::*;
#(
  parameter int TICK_DIV        = DEF_TICK_DIV,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int BTN_ON_TICKS    = 8,
  parameter int BTN_OFF_TICKS   = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic       host_valid,
  output logic       host_ready,
  input  logic [3:0] host_count,
  input  logic [7:0] host_on,
  input  logic [7:0] host_off,
  output logic       btn_out,
  output logic       busy,
  output logic       grant_id,
  output logic       done,
  output logic [1:0] state_dbg
);

  localparam int TW = cnt_width(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [7:0] BTN_ON_LEN  = at_least_one(8'(BTN_ON_TICKS));
  localparam logic [7:0] BTN_OFF_LEN = at_least_one(8'(BTN_OFF_TICKS));

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic [7:0]    phase_ticks;
  logic [3:0]    remaining;
  logic [7:0]    on_len;
  logic [7:0]    off_len;
  logic          last_grant;
  logic          btn_pending;
  logic          btn_rise;
  logic          grant_btn;
  logic          tick_wrap;
  logic          on_end;
  logic          off_end;
  logic [3:0]    grant_count;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock  (clock),
    .reset  (reset),
    .btn_raw(btn_raw),
    .rise   (btn_rise)
  );

  // Round-robin: the host loses a tie only when it held the last grant.
  assign host_ready  = (state == IDLE) && host_valid &&
                       (!btn_pending || last_grant == REQ_BTN);
  assign grant_btn   = (state == IDLE) && btn_pending && !host_ready;
  assign grant_count = host_ready ? host_count : 4'd1;

  // A phase of N ticks ends on the last cycle of its (N-1)-th tick.
  assign tick_wrap = (tick_cnt == TICK_LAST);
  assign on_end    = tick_wrap && (phase_ticks == on_len - 8'd1);
  assign off_end   = tick_wrap && (phase_ticks == off_len - 8'd1);
  assign state_dbg = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      phase_ticks <= '0;
      remaining   <= '0;
      on_len      <= '0;
      off_len     <= '0;
      last_grant  <= REQ_HOST;
      btn_pending <= 1'b0;
      btn_out     <= 1'b0;
      busy        <= 1'b0;
      grant_id    <= REQ_BTN;
      done        <= 1'b0;
    end else begin
      done        <= 1'b0;
      tick_cnt    <= tick_wrap ? '0 : tick_cnt + 1'b1;
      phase_ticks <= tick_wrap ? phase_ticks + 8'd1 : phase_ticks;
      // Edges arriving while already pending are absorbed; a grant in the
      // same cycle clears it below and wins.
      if (btn_rise) btn_pending <= 1'b1;

      case (state)
        IDLE: begin
          if (host_ready || grant_btn) begin
            tick_cnt    <= '0;
            phase_ticks <= '0;
            grant_id    <= host_ready ? REQ_HOST : REQ_BTN;
            last_grant  <= host_ready ? REQ_HOST : REQ_BTN;
            remaining   <= grant_count;
            on_len      <= host_ready ? at_least_one(host_on)  : BTN_ON_LEN;
            off_len     <= host_ready ? at_least_one(host_off) : BTN_OFF_LEN;
            if (grant_btn) btn_pending <= 1'b0;
            busy        <= 1'b1;
            if (grant_count == 4'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= ON;
              btn_out <= 1'b1;
            end
          end
        end
        ON: begin
          if (on_end) begin
            tick_cnt    <= '0;
            phase_ticks <= '0;
            state       <= OFF;
            btn_out     <= 1'b0;
          end
        end
        OFF: begin
          if (off_end) begin
            tick_cnt    <= '0;
            phase_ticks <= '0;
            remaining   <= remaining - 4'd1;
            if (remaining != 4'd1) begin
              state   <= ON;
              btn_out <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          tick_cnt    <= '0;
          phase_ticks <= '0;
          state       <= IDLE;
          busy        <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          btn_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
